roc_tick_sched: RTL and testbench

Parametrised tick scheduler that replaces the divided-clock TPS generator: it produces a single-cycle tick enable for the redstone core from the system clock. It sits between the command controller and RoC. Mode commands arrive over a valid/ready handshake. It supports exact fractional-rate run mode, N-tick single-step, and free-running maximum speed. Ticks are held off while RoC signals busy; owed ticks are remembered, with overrun detection and a wrapping tick counter.

---
 rtl/roc_tick_pkg.sv | 28 ++
 rtl/tick_rate_acc.sv | 44 ++++
 rtl/roc_tick_sched.sv | 143 ++++++++++++++
 tb/tb_roc_tick_sched.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/roc_tick_pkg.sv
// Shared types for the redstone-core tick scheduler: mode enum and command opcodes.
package roc_tick_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_FREE = 2'd3
  } tick_state_e;

  localparam logic [1:0] OP_STOP = 2'd0;
  localparam logic [1:0] OP_RUN  = 2'd1;
  localparam logic [1:0] OP_STEP = 2'd2;
  localparam logic [1:0] OP_FREE = 2'd3;

  // Mode entered when a command with this opcode is accepted.
  function automatic tick_state_e op_to_state(input logic [1:0] op);
    tick_state_e st;
    case (op)
      OP_RUN:  st = ST_RUN;
      OP_STEP: st = ST_STEP;
      OP_FREE: st = ST_FREE;
      default: st = ST_IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/tick_rate_acc.sv
// Phase accumulator for RUN mode: adds the clamped rate every cycle and emits a
// credit each time the running total crosses CLK_HZ, keeping the residue so
// fractional rates come out exact on average.
module tick_rate_acc #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned TPS_W  = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [TPS_W-1:0] i_rate,
  input  logic             i_clear,
  output logic             o_credit
);

  localparam logic [TPS_W:0] LP_HZ = (TPS_W+1)'(CLK_HZ);

  logic [TPS_W:0] r_acc;
  logic [TPS_W:0] w_rate;
  logic [TPS_W:0] w_sum;

  // Clamp the rate to CLK_HZ so at most one credit is produced per cycle.
  always_comb begin
    w_rate = {1'b0, i_rate};
    if (w_rate > LP_HZ) begin
      w_rate = LP_HZ;
    end
    w_sum    = r_acc + w_rate;
    o_credit = (w_sum >= LP_HZ);
  end

  // Accumulator register; clear wins over accumulation.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (o_credit) begin
      r_acc <= w_sum - LP_HZ;
    end else begin
      r_acc <= w_sum;
    end
  end

endmodule

// File: rtl/roc_tick_sched.sv
// Tick scheduler for the redstone core: turns mode commands (STOP/RUN/STEP/FREE)
// into single-cycle tick enables, holding off while RoC is busy and remembering
// owed ticks in RUN mode.
module roc_tick_sched
  import roc_tick_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TPS_W   = 32,
  parameter int unsigned STEP_W  = 16,
  parameter int unsigned CNT_W   = 48,
  parameter int unsigned PEND_W  = 4,
  parameter int unsigned MIN_GAP = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_op,
  input  logic [STEP_W-1:0] i_cmd_arg,
  input  logic [TPS_W-1:0]  i_tps,
  input  logic              i_hold,
  output logic              o_tick,
  output logic [1:0]        o_state,
  output logic [PEND_W-1:0] o_pending,
  output logic              o_overrun,
  output logic [CNT_W-1:0]  o_tick_count
);

  localparam int unsigned     GAP_W       = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0] LP_GAP_MAX = GAP_W'(MIN_GAP - 1);
  localparam logic [PEND_W-1:0] LP_PEND_MAX = '1;

  tick_state_e       r_state;
  logic              r_cmd_ready;
  logic              r_tick;
  logic              r_overrun;
  logic [PEND_W-1:0] r_pending;
  logic [STEP_W-1:0] r_remaining;
  logic [GAP_W-1:0]  r_gap;
  logic [CNT_W-1:0]  r_tick_count;

  logic              w_accept;
  logic              w_gap_ok;
  logic              w_fire;
  logic              w_credit;
  logic              w_run_credit;
  logic              w_run_fire;
  logic [TPS_W-1:0]  w_rate;
  logic [PEND_W-1:0] w_pend_next;

  // Accumulator only sees a non-zero rate in RUN, so it is idle elsewhere.
  tick_rate_acc #(
    .CLK_HZ (CLK_HZ),
    .TPS_W  (TPS_W)
  ) u_rate_acc (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_rate   (w_rate),
    .i_clear  (w_accept),
    .o_credit (w_credit)
  );

  // Accept, emission and owed-tick decisions for the coming edge.
  always_comb begin
    w_accept     = i_cmd_valid & r_cmd_ready;
    w_gap_ok     = (r_gap >= LP_GAP_MAX);
    w_rate       = (r_state == ST_RUN) ? i_tps : '0;
    w_run_credit = w_credit && (r_state == ST_RUN);
    w_fire       = 1'b0;
    case (r_state)
      ST_RUN:  w_fire = (r_pending != '0) && !i_hold && w_gap_ok;
      ST_STEP: w_fire = (r_remaining != '0) && !i_hold && w_gap_ok;
      ST_FREE: w_fire = !i_hold && w_gap_ok;
      default: w_fire = 1'b0;
    endcase
    w_run_fire = w_fire && (r_state == ST_RUN);

    w_pend_next = r_pending;
    if (w_run_credit && !w_run_fire) begin
      if (r_pending != LP_PEND_MAX) begin
        w_pend_next = r_pending + 1'b1;
      end
    end else if (!w_run_credit && w_run_fire) begin
      w_pend_next = r_pending - 1'b1;
    end
  end

  // Mode FSM, handshake and all counters; every output is registered here.
  // The tick for an edge is decided from the old mode even when a command is
  // accepted at that same edge, so a STOP never retracts an in-flight tick.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= ST_IDLE;
      r_cmd_ready  <= 1'b0;
      r_tick       <= 1'b0;
      r_overrun    <= 1'b0;
      r_pending    <= '0;
      r_remaining  <= '0;
      r_gap        <= '0;
      r_tick_count <= '0;
    end else begin
      r_cmd_ready <= !w_accept;
      r_tick      <= w_fire;
      if (w_fire) begin
        r_tick_count <= r_tick_count + 1'b1;
      end
      if (w_accept) begin
        r_state     <= op_to_state(i_cmd_op);
        r_pending   <= '0;
        r_gap       <= '0;
        r_remaining <= (i_cmd_arg == '0) ? STEP_W'(1) : i_cmd_arg;
        if (i_cmd_op == OP_STOP) begin
          r_overrun <= 1'b0;
        end
      end else begin
        r_pending <= w_pend_next;
        if (w_run_credit && (r_pending == LP_PEND_MAX)) begin
          r_overrun <= 1'b1;
        end
        if (w_fire) begin
          r_gap <= '0;
        end else if (!w_gap_ok) begin
          r_gap <= r_gap + 1'b1;
        end
        if (r_state == ST_STEP) begin
          if (w_fire) begin
            r_remaining <= r_remaining - 1'b1;
          end else if (r_remaining == '0) begin
            r_state <= ST_IDLE;
          end
        end
      end
    end
  end

  assign o_cmd_ready  = r_cmd_ready;
  assign o_tick       = r_tick;
  assign o_state      = r_state;
  assign o_pending    = r_pending;
  assign o_overrun    = r_overrun;
  assign o_tick_count = r_tick_count;

endmodule

// File: tb/tb_roc_tick_sched.sv
// Bench for roc_tick_sched: scenario tasks plus a randomized run, all checked
// against a cycle model that derives RUN credits from the running rate sum.
module tb_roc_tick_sched;

  localparam int HZ       = 100;
  localparam int TPS_W    = 8;
  localparam int STEP_W   = 8;
  localparam int CNT_W    = 4;
  localparam int PEND_W   = 2;
  localparam int MIN_GAP  = 2;
  localparam int PEND_MAX = (1 << PEND_W) - 1;
  localparam int CNT_MOD  = 1 << CNT_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_cmd_valid = 1'b0;
  logic              o_cmd_ready;
  logic [1:0]        i_cmd_op = 2'd0;
  logic [STEP_W-1:0] i_cmd_arg = '0;
  logic [TPS_W-1:0]  i_tps = '0;
  logic              i_hold = 1'b0;
  logic              o_tick;
  logic [1:0]        o_state;
  logic [PEND_W-1:0] o_pending;
  logic              o_overrun;
  logic [CNT_W-1:0]  o_tick_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state
  int     m_mode, m_pend, m_gap, m_rem, m_count;
  logic   m_ready, m_tick, m_over;
  longint m_sum, m_credits;

  always #5 clk = ~clk;

  roc_tick_sched #(
    .CLK_HZ  (HZ),
    .TPS_W   (TPS_W),
    .STEP_W  (STEP_W),
    .CNT_W   (CNT_W),
    .PEND_W  (PEND_W),
    .MIN_GAP (MIN_GAP)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_op     (i_cmd_op),
    .i_cmd_arg    (i_cmd_arg),
    .i_tps        (i_tps),
    .i_hold       (i_hold),
    .o_tick       (o_tick),
    .o_state      (o_state),
    .o_pending    (o_pending),
    .o_overrun    (o_overrun),
    .o_tick_count (o_tick_count)
  );

  task automatic model_reset();
    m_mode = 0; m_pend = 0; m_gap = 0; m_rem = 0; m_count = 0;
    m_ready = 1'b0; m_tick = 1'b0; m_over = 1'b0;
    m_sum = 0; m_credits = 0;
  endtask

  // One clock edge of the specified behaviour; credits owed in RUN are the
  // whole multiples of HZ in the total rate summed since the mode was entered.
  task automatic model_edge();
    logic acc, fire, credit, gap_ok;
    int   r;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acc    = i_cmd_valid && m_ready;
    gap_ok = (m_gap >= MIN_GAP - 1);
    credit = 1'b0;
    if (m_mode == 1) begin
      r = (int'(i_tps) > HZ) ? HZ : int'(i_tps);
      m_sum += r;
      if (m_sum / HZ > m_credits) begin
        credit = 1'b1;
        m_credits++;
      end
    end
    case (m_mode)
      1:       fire = (m_pend > 0) && !i_hold && gap_ok;
      2:       fire = (m_rem > 0) && !i_hold && gap_ok;
      3:       fire = !i_hold && gap_ok;
      default: fire = 1'b0;
    endcase
    m_tick = fire;
    if (fire) m_count = (m_count + 1) % CNT_MOD;
    m_ready = !acc;
    if (acc) begin
      m_mode = int'(i_cmd_op);
      m_pend = 0; m_gap = 0; m_sum = 0; m_credits = 0;
      if (i_cmd_op == 2'd0) m_over = 1'b0;
      m_rem = (i_cmd_arg == 0) ? 1 : int'(i_cmd_arg);
    end else begin
      if (m_mode == 1) begin
        if (credit && m_pend == PEND_MAX) m_over = 1'b1;
        m_pend = m_pend + int'(credit) - int'(fire);
        if (m_pend > PEND_MAX) m_pend = PEND_MAX;
      end
      m_gap = fire ? 0 : ((m_gap < MIN_GAP - 1) ? m_gap + 1 : m_gap);
      if (m_mode == 2) begin
        if (fire) m_rem--;
        else if (m_rem == 0) m_mode = 0;
      end
    end
  endtask

  // Advance one clock, update the model, land 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input int arg);
    for (int w = 0; w < 4 && !o_cmd_ready; w++) cyc();
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_arg   = STEP_W'(arg);
    cyc();
    i_cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    total_cnt++; if (o_tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", o_tick); else pass_cnt++;
    total_cnt++; if (o_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", o_state); else pass_cnt++;
    total_cnt++; if (o_pending !== '0) $display("FAIL reset_pending: got %0d want 0", o_pending); else pass_cnt++;
    total_cnt++; if (o_overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", o_overrun); else pass_cnt++;
    total_cnt++; if (o_tick_count !== '0) $display("FAIL reset_count: got %0d want 0", o_tick_count); else pass_cnt++;
    total_cnt++; if (o_cmd_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", o_cmd_ready); else pass_cnt++;
    rst_n = 1'b1;
    cyc();
    total_cnt++; if (o_cmd_ready !== 1'b1) $display("FAIL ready_after_release: got %b want 1", o_cmd_ready); else pass_cnt++;
  endtask

  task automatic test_run_rate();
    int times[$];
    int bad_gap = 0, in_win = 0;
    i_tps = TPS_W'(25);
    send_cmd(2'd1, 0);
    for (int c = 0; c < 130; c++) begin
      cyc();
      total_cnt++; if (o_tick !== m_tick) $display("FAIL run25_tick c=%0d: got %b want %b", c, o_tick, m_tick); else pass_cnt++;
      if (o_tick === 1'b1) times.push_back(c);
    end
    for (int i = 1; i < times.size(); i++) if (times[i] - times[i-1] != 4) bad_gap++;
    if (times.size() > 0) foreach (times[i]) if (times[i] < times[0] + 100) in_win++;
    total_cnt++; if (bad_gap != 0 || times.size() == 0) $display("FAIL run25_spacing: got %0d bad gaps over %0d ticks want 0", bad_gap, times.size()); else pass_cnt++;
    total_cnt++; if (in_win != 25) $display("FAIL run25_per100: got %0d want 25", in_win); else pass_cnt++;
    total_cnt++; if (o_tick_count !== CNT_W'(m_count)) $display("FAIL run25_count: got %0d want %0d", o_tick_count, m_count); else pass_cnt++;
  endtask

  task automatic test_fractional();
    int times[$];
    int bad_gap = 0, in_win = 0;
    i_tps = TPS_W'(30);
    send_cmd(2'd1, 0);
    for (int c = 0; c < 130; c++) begin
      cyc();
      total_cnt++; if (o_tick !== m_tick) $display("FAIL run30_tick c=%0d: got %b want %b", c, o_tick, m_tick); else pass_cnt++;
      if (o_tick === 1'b1) times.push_back(c);
    end
    for (int i = 1; i < times.size(); i++)
      if (times[i] - times[i-1] < 3 || times[i] - times[i-1] > 4) bad_gap++;
    if (times.size() > 0) foreach (times[i]) if (times[i] < times[0] + 100) in_win++;
    total_cnt++; if (bad_gap != 0 || times.size() == 0) $display("FAIL run30_spacing: got %0d bad gaps want 0", bad_gap); else pass_cnt++;
    total_cnt++; if (in_win != 30) $display("FAIL run30_per100: got %0d want 30", in_win); else pass_cnt++;
  endtask

  task automatic test_step_hold();
    int ticks = 0, last = -100, hold_left = 0, bad_gap = 0, bad_hold = 0, done_at = -1;
    logic h;
    send_cmd(2'd2, 5);
    for (int c = 0; c < 80; c++) begin
      h = i_hold;
      cyc();
      total_cnt++; if (o_tick !== m_tick) $display("FAIL step_tick c=%0d: got %b want %b", c, o_tick, m_tick); else pass_cnt++;
      total_cnt++; if (o_state !== 2'(m_mode)) $display("FAIL step_state c=%0d: got %0d want %0d", c, o_state, m_mode); else pass_cnt++;
      if (o_tick === 1'b1) begin
        ticks++;
        if (h) bad_hold++;
        if (c - last < 2) bad_gap++;
        last = c;
        if (ticks == 2) hold_left = 10;
        if (ticks == 5) done_at = c;
      end
      if (done_at >= 0 && c == done_at + 1) begin
        total_cnt++; if (o_state !== 2'd0) $display("FAIL step_idle_after_last: got %0d want 0", o_state); else pass_cnt++;
      end
      if (hold_left > 0) begin
        i_hold = 1'b1;
        hold_left--;
      end else begin
        i_hold = 1'b0;
      end
    end
    total_cnt++; if (ticks != 5) $display("FAIL step_total: got %0d want 5", ticks); else pass_cnt++;
    total_cnt++; if (bad_hold != 0) $display("FAIL step_tick_while_held: got %0d want 0", bad_hold); else pass_cnt++;
    total_cnt++; if (bad_gap != 0) $display("FAIL step_min_gap: got %0d want 0", bad_gap); else pass_cnt++;
  endtask

  task automatic test_saturation();
    int times[$];
    int bad_gap = 0;
    i_hold = 1'b1;
    i_tps  = TPS_W'(200);
    send_cmd(2'd1, 0);
    for (int c = 0; c < 20; c++) begin
      cyc();
      total_cnt++; if (o_pending !== PEND_W'(m_pend)) $display("FAIL sat_pending c=%0d: got %0d want %0d", c, o_pending, m_pend); else pass_cnt++;
    end
    total_cnt++; if (o_pending !== PEND_W'(3)) $display("FAIL sat_pending_full: got %0d want 3", o_pending); else pass_cnt++;
    total_cnt++; if (o_overrun !== 1'b1) $display("FAIL sat_overrun: got %b want 1", o_overrun); else pass_cnt++;
    i_hold = 1'b0;
    for (int c = 0; c < 30; c++) begin
      cyc();
      total_cnt++; if (o_tick !== m_tick) $display("FAIL sat_drain_tick c=%0d: got %b want %b", c, o_tick, m_tick); else pass_cnt++;
      if (o_tick === 1'b1) times.push_back(c);
    end
    for (int i = 1; i < times.size(); i++) if (times[i] - times[i-1] != MIN_GAP) bad_gap++;
    total_cnt++; if (times.size() != 15 || times[0] != 0) $display("FAIL sat_drain_count: got %0d ticks want 15 starting at once", times.size()); else pass_cnt++;
    total_cnt++; if (bad_gap != 0) $display("FAIL sat_cadence: got %0d bad gaps want 0", bad_gap); else pass_cnt++;
  endtask

  task automatic test_handshake_stop();
    int late = 0;
    i_cmd_valid = 1'b1;
    i_cmd_op    = 2'd0;
    cyc();
    total_cnt++; if (o_cmd_ready !== 1'b0) $display("FAIL stop_ready_low: got %b want 0", o_cmd_ready); else pass_cnt++;
    total_cnt++; if (o_pending !== '0) $display("FAIL stop_pending: got %0d want 0", o_pending); else pass_cnt++;
    total_cnt++; if (o_overrun !== 1'b0) $display("FAIL stop_overrun: got %b want 0", o_overrun); else pass_cnt++;
    total_cnt++; if (o_state !== 2'd0) $display("FAIL stop_state: got %0d want 0", o_state); else pass_cnt++;
    total_cnt++; if (o_tick !== m_tick) $display("FAIL stop_inflight_tick: got %b want %b", o_tick, m_tick); else pass_cnt++;
    cyc();
    total_cnt++; if (o_cmd_ready !== 1'b1) $display("FAIL stop_single_accept: got ready %b want 1", o_cmd_ready); else pass_cnt++;
    i_cmd_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (o_tick !== 1'b0) late++;
      cyc();
    end
    total_cnt++; if (late != 0) $display("FAIL stop_no_late_ticks: got %0d want 0", late); else pass_cnt++;
  endtask

  task automatic test_wrap_reset();
    logic [CNT_W-1:0] prev;
    int wraps = 0;
    send_cmd(2'd3, 0);
    prev = o_tick_count;
    for (int c = 0; c < 40; c++) begin
      cyc();
      total_cnt++; if (o_tick_count !== CNT_W'(m_count)) $display("FAIL free_count c=%0d: got %0d want %0d", c, o_tick_count, m_count); else pass_cnt++;
      if (prev == '1 && o_tick_count == '0) wraps++;
      prev = o_tick_count;
    end
    total_cnt++; if (wraps < 1) $display("FAIL count_wrap: got %0d wraps want >=1", wraps); else pass_cnt++;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (o_tick !== 1'b0) $display("FAIL async_tick: got %b want 0", o_tick); else pass_cnt++;
    total_cnt++; if (o_state !== 2'd0) $display("FAIL async_state: got %0d want 0", o_state); else pass_cnt++;
    total_cnt++; if (o_tick_count !== '0) $display("FAIL async_count: got %0d want 0", o_tick_count); else pass_cnt++;
    total_cnt++; if (o_cmd_ready !== 1'b0) $display("FAIL async_ready: got %b want 0", o_cmd_ready); else pass_cnt++;
    total_cnt++; if (o_pending !== '0 || o_overrun !== 1'b0) $display("FAIL async_pend_ovr: got %0d/%b want 0/0", o_pending, o_overrun); else pass_cnt++;
    model_reset();
    cyc();
    rst_n = 1'b1;
    cyc();
    total_cnt++; if (o_cmd_ready !== 1'b1) $display("FAIL async_release_ready: got %b want 1", o_cmd_ready); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      i_cmd_valid = ($urandom_range(0, 7) == 0);
      i_cmd_op    = 2'($urandom_range(0, 3));
      i_cmd_arg   = STEP_W'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) i_tps = TPS_W'($urandom_range(0, 255));
      i_hold      = ($urandom_range(0, 3) == 0);
      cyc();
      total_cnt++; if (o_tick !== m_tick) $display("FAIL rnd_tick c=%0d: got %b want %b", c, o_tick, m_tick); else pass_cnt++;
      total_cnt++; if (o_state !== 2'(m_mode)) $display("FAIL rnd_state c=%0d: got %0d want %0d", c, o_state, m_mode); else pass_cnt++;
      total_cnt++; if (o_pending !== PEND_W'(m_pend)) $display("FAIL rnd_pending c=%0d: got %0d want %0d", c, o_pending, m_pend); else pass_cnt++;
      total_cnt++; if (o_overrun !== m_over) $display("FAIL rnd_overrun c=%0d: got %b want %b", c, o_overrun, m_over); else pass_cnt++;
      total_cnt++; if (o_tick_count !== CNT_W'(m_count)) $display("FAIL rnd_count c=%0d: got %0d want %0d", c, o_tick_count, m_count); else pass_cnt++;
      total_cnt++; if (o_cmd_ready !== m_ready) $display("FAIL rnd_ready c=%0d: got %b want %b", c, o_cmd_ready, m_ready); else pass_cnt++;
    end
    i_cmd_valid = 1'b0;
    i_hold      = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run_rate();
    test_fractional();
    test_step_hold();
    test_saturation();
    test_handshake_stop();
    test_wrap_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
